muldiv_ctrl: RTL and testbench

//   Sequencer for the shared MULT/DIV units of the multicycle CPU. Accepts one op from
//   the control unit, latches operands, launches the selected unit, waits for its done,
//   and writes the HI/LO architectural registers. Checks for divide-by-zero before launch.

---
 rtl/muldiv_ctrl.sv | 137 +++++++++++++
 tb/tb_muldiv_ctrl.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: launches one MULT/DIV op, waits for the unit, writes HI/LO; also serves MTHI/MTLO.
// Latency >=4 cycles start->done (2 on divide-by-zero); start/MTHI/MTLO ignored while busy, no queuing.
// MULDIV_TIMEOUT_EN: abort a WAIT after TIMEOUT cycles with timeout_err.
module muldiv_ctrl #(
  parameter int W       = 32,
  parameter int TIMEOUT = 40
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         hi_we,
  input  logic         lo_we,
  input  logic [W-1:0] wdata,
  output logic         mult_start,
  output logic         div_start,
  output logic [W-1:0] unit_a,
  output logic [W-1:0] unit_b,
  input  logic         mult_done,
  input  logic [W-1:0] mult_hi,
  input  logic [W-1:0] mult_lo,
  input  logic         div_done,
  input  logic [W-1:0] div_hi,
  input  logic [W-1:0] div_lo,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         div0,
  output logic         timeout_err
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FIN} state_t;

  state_t       state;
  logic         op_q;
  logic         sel_done;
  logic [W-1:0] sel_hi;
  logic [W-1:0] sel_lo;

  if (TIMEOUT < 1) begin : g_timeout_check
    $error("muldiv_ctrl: TIMEOUT must be at least 1");
  end

  // Only the unit that was launched may complete the op.
  assign sel_done = op_q ? div_done : mult_done;
  assign sel_hi   = op_q ? div_hi   : mult_hi;
  assign sel_lo   = op_q ? div_lo   : mult_lo;

`ifdef MULDIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= IDLE;
      op_q       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      unit_a     <= '0;
      unit_b     <= '0;
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div0       <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
`endif
    end else begin
      mult_start <= 1'b0;
      div_start  <= 1'b0;
      done       <= 1'b0;
      div0       <= 1'b0;
`ifdef MULDIV_TIMEOUT_EN
      timeout_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            if (op && (B == '0)) begin
              state <= FIN;
              done  <= 1'b1;
              div0  <= 1'b1;
            end else begin
              op_q       <= op;
              unit_a     <= A;
              unit_b     <= B;
              state      <= LAUNCH;
              busy       <= 1'b1;
              mult_start <= ~op;
              div_start  <= op;
            end
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        LAUNCH: begin
          state <= WAIT;
`ifdef MULDIV_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (sel_done) begin
            hi    <= sel_hi;
            lo    <= sel_lo;
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`ifdef MULDIV_TIMEOUT_EN
          // A done arriving on the limit cycle takes the branch above.
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            state       <= FIN;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: the bench plays both arithmetic units.
module tb_muldiv_ctrl;
  localparam int W   = 32;
  localparam int TMO = 40;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         hi_we = 1'b0;
  logic         lo_we = 1'b0;
  logic [W-1:0] wdata = '0;
  logic         mult_start, div_start;
  logic [W-1:0] unit_a, unit_b;
  logic         mult_done = 1'b0;
  logic [W-1:0] mult_hi = '0;
  logic [W-1:0] mult_lo = '0;
  logic         div_done = 1'b0;
  logic [W-1:0] div_hi = '0;
  logic [W-1:0] div_lo = '0;
  logic [W-1:0] hi, lo;
  logic         busy, done, div0, timeout_err;

  always #5 clock = ~clock;

  muldiv_ctrl #(.W(W), .TIMEOUT(TMO)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .mult_start(mult_start), .div_start(div_start), .unit_a(unit_a), .unit_b(unit_b),
    .mult_done(mult_done), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_done(div_done), .div_hi(div_hi), .div_lo(div_lo),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div0(div0), .timeout_err(timeout_err)
  );

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div0;
    logic         tmo;
  } exp_t;

  exp_t sbq[$];
  int n_checks = 0;
  int n_fail   = 0;
  int ms_cnt   = 0;
  int ds_cnt   = 0;
  int done_cnt = 0;

  // Registered outputs are stable across the cycle; count high cycles at each edge.
  always @(posedge clock) begin
    if (mult_start === 1'b1) ms_cnt++;
    if (div_start === 1'b1) ds_cnt++;
    if (done === 1'b1) done_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic issue(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic unit_pulse(input logic which, input logic [W-1:0] h, input logic [W-1:0] l);
    if (which) begin div_done = 1'b1; div_hi = h; div_lo = l; end
    else begin mult_done = 1'b1; mult_hi = h; mult_lo = l; end
    @(negedge clock);
    mult_done = 1'b0;
    div_done  = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int waited);
    waited = 0;
    while (done !== 1'b1 && waited < limit) begin
      @(negedge clock);
      waited++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    cyc(2);
    n_checks++;
    if ({hi, lo, unit_a, unit_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: got hi=%h lo=%h a=%h b=%h want all 0", hi, lo, unit_a, unit_b);
    end
    n_checks++;
    if ({busy, done, div0, timeout_err, mult_start, div_start} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, done, div0, timeout_err, mult_start, div_start});
    end
    reset = 1'b1;
    cyc(1);
  endtask

  task automatic test_mult;
    int m0 = ms_cnt, d0 = ds_cnt, w;
    exp_t e;
    sbq.push_back('{hi: 32'd0, lo: 32'd42, div0: 1'b0, tmo: 1'b0});
    issue(1'b0, 32'd7, 32'd6);
    n_checks++;
    if ({mult_start, div_start, busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL mult_launch: got ms/ds/busy=%b want 101", {mult_start, div_start, busy});
    end
    cyc(3);
    unit_pulse(1'b0, 32'd0, 32'd42);
    wait_done(10, w);
    n_checks++;
    if (done !== 1'b1 || w != 0) begin
      n_fail++;
      $display("FAIL mult_done_time: got done=%b after %0d extra cycles want 1 after 0", done, w);
    end
    n_checks++;
    if (sbq.size() == 0) begin
      n_fail++; $display("FAIL mult_result: scoreboard empty");
    end else begin
      e = sbq.pop_front();
      if ({hi, lo, div0, timeout_err} !== {e.hi, e.lo, e.div0, e.tmo}) begin
        n_fail++;
        $display("FAIL mult_result: got hi=%h lo=%h div0=%b tmo=%b want %h %h %b %b",
                 hi, lo, div0, timeout_err, e.hi, e.lo, e.div0, e.tmo);
      end
    end
    cyc(1);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0 || ms_cnt != m0 + 1 || ds_cnt != d0) begin
      n_fail++;
      $display("FAIL mult_pulses: got done=%b busy=%b mult_starts=%0d div_starts=%0d want 0 0 1 0",
               done, busy, ms_cnt - m0, ds_cnt - d0);
    end
  endtask

  task automatic test_div;
    int m0 = ms_cnt, d0 = ds_cnt;
    exp_t e;
    sbq.push_back('{hi: 32'd2, lo: 32'd14, div0: 1'b0, tmo: 1'b0});
    issue(1'b1, 32'd100, 32'd7);
    cyc(1);
    n_checks++;
    if (unit_a !== 32'd100 || unit_b !== 32'd7 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL div_operands: got a=%0d b=%0d done=%b want 100 7 0", unit_a, unit_b, done);
    end
    unit_pulse(1'b1, 32'd2, 32'd14);
    // Unit answered in the first WAIT cycle: done must be up exactly now.
    n_checks++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL div_min_latency: got done=%b want 1", done);
    end
    n_checks++;
    if (sbq.size() == 0) begin
      n_fail++; $display("FAIL div_result: scoreboard empty");
    end else begin
      e = sbq.pop_front();
      if ({hi, lo, div0, timeout_err} !== {e.hi, e.lo, e.div0, e.tmo}) begin
        n_fail++;
        $display("FAIL div_result: got hi=%h lo=%h div0=%b tmo=%b want %h %h %b %b",
                 hi, lo, div0, timeout_err, e.hi, e.lo, e.div0, e.tmo);
      end
    end
    cyc(1);
    n_checks++;
    if (ms_cnt != m0 || ds_cnt != d0 + 1) begin
      n_fail++;
      $display("FAIL div_launch_count: got mult=%0d div=%0d want 0 1", ms_cnt - m0, ds_cnt - d0);
    end
  endtask

  task automatic test_div0;
    int d0 = ds_cnt;
    exp_t e;
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h33;
    cyc(1);
    n_checks++;
    if (hi !== 32'h33 || lo !== 32'h33) begin
      n_fail++; $display("FAIL mt_both: got hi=%h lo=%h want 33 33", hi, lo);
    end
    lo_we = 1'b0; wdata = 32'd5;
    cyc(1);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'd9;
    cyc(1);
    lo_we = 1'b0;
    n_checks++;
    if (hi !== 32'd5 || lo !== 32'd9) begin
      n_fail++; $display("FAIL mthi_mtlo: got hi=%h lo=%h want 5 9", hi, lo);
    end
    sbq.push_back('{hi: 32'd5, lo: 32'd9, div0: 1'b1, tmo: 1'b0});
    issue(1'b1, 32'd123, 32'd0);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL div0_timing: got done=%b busy=%b want 1 0", done, busy);
    end
    n_checks++;
    if (sbq.size() == 0) begin
      n_fail++; $display("FAIL div0_result: scoreboard empty");
    end else begin
      e = sbq.pop_front();
      if ({hi, lo, div0, timeout_err} !== {e.hi, e.lo, e.div0, e.tmo}) begin
        n_fail++;
        $display("FAIL div0_result: got hi=%h lo=%h div0=%b tmo=%b want %h %h %b %b",
                 hi, lo, div0, timeout_err, e.hi, e.lo, e.div0, e.tmo);
      end
    end
    n_checks++;
    if (unit_a !== 32'd100 || unit_b !== 32'd7) begin
      n_fail++; $display("FAIL div0_operands_held: got a=%0d b=%0d want 100 7", unit_a, unit_b);
    end
    cyc(1);
    n_checks++;
    if (done !== 1'b0 || div0 !== 1'b0 || ds_cnt != d0) begin
      n_fail++;
      $display("FAIL div0_pulse: got done=%b div0=%b div_starts=%0d want 0 0 0", done, div0, ds_cnt - d0);
    end
  endtask

  task automatic test_ignored_inputs;
    int m0 = ms_cnt, d0 = ds_cnt, dc0, w;
    exp_t e;
    sbq.push_back('{hi: 32'd2, lo: 32'd16, div0: 1'b0, tmo: 1'b0});
    hi_we = 1'b1; wdata = 32'hdead;
    issue(1'b1, 32'd50, 32'd3);
    hi_we = 1'b0;
    // A done while still launching must not complete the op.
    div_done = 1'b1; div_hi = 32'd77; div_lo = 32'd77;
    cyc(1);
    div_done = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL launch_done_ignored: got done=%b busy=%b want 0 1", done, busy);
    end
    start = 1'b1; op = 1'b0; A = 32'd9; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hbad;
    mult_done = 1'b1; mult_hi = 32'h111; mult_lo = 32'h222;
    cyc(1);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0; mult_done = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1 || hi !== 32'd5 || lo !== 32'd9) begin
      n_fail++;
      $display("FAIL stray_ignored: got done=%b busy=%b hi=%h lo=%h want 0 1 5 9", done, busy, hi, lo);
    end
    dc0 = done_cnt;
    unit_pulse(1'b1, 32'd2, 32'd16);
    wait_done(5, w);
    n_checks++;
    if (sbq.size() == 0) begin
      n_fail++; $display("FAIL ignore_result: scoreboard empty");
    end else begin
      e = sbq.pop_front();
      if (done !== 1'b1 || {hi, lo, div0, timeout_err} !== {e.hi, e.lo, e.div0, e.tmo}) begin
        n_fail++;
        $display("FAIL ignore_result: got done=%b hi=%h lo=%h div0=%b tmo=%b want 1 %h %h %b %b",
                 done, hi, lo, div0, timeout_err, e.hi, e.lo, e.div0, e.tmo);
      end
    end
    n_checks++;
    if (unit_a !== 32'd50) begin
      n_fail++; $display("FAIL unit_a_held: got %0d want 50", unit_a);
    end
    cyc(4);
    n_checks++;
    if (ms_cnt != m0 || ds_cnt != d0 + 1 || busy !== 1'b0 || done_cnt != dc0 + 1) begin
      n_fail++;
      $display("FAIL no_requeue: got mult=%0d div=%0d busy=%b dones=%0d want 0 1 0 1",
               ms_cnt - m0, ds_cnt - d0, busy, done_cnt - dc0);
    end
  endtask

  task automatic test_reset_mid;
    int dc0 = done_cnt;
    issue(1'b1, 32'd40, 32'd5);
    cyc(1);
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    n_checks++;
    if ({hi, lo, unit_a, unit_b} !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_state: got hi=%h lo=%h a=%h b=%h busy=%b want all 0",
               hi, lo, unit_a, unit_b, busy);
    end
    unit_pulse(1'b1, 32'd3, 32'd4);
    cyc(3);
    n_checks++;
    if (done_cnt != dc0 || hi !== '0 || lo !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_late_done: got dones=%0d hi=%h lo=%h busy=%b want 0 0 0 0",
               done_cnt - dc0, hi, lo, busy);
    end
  endtask

  task automatic test_timeout;
    int w;
    exp_t e;
    hi_we = 1'b1; wdata = 32'h1234;
    cyc(1);
    hi_we = 1'b0;
`ifdef MULDIV_TIMEOUT_EN
    sbq.push_back('{hi: 32'h1234, lo: 32'd0, div0: 1'b0, tmo: 1'b1});
    issue(1'b0, 32'd3, 32'd3);
    wait_done(60, w);
    n_checks++;
    if (done !== 1'b1 || w != TMO + 1) begin
      n_fail++; $display("FAIL timeout_latency: got done=%b after %0d want 1 after %0d", done, w, TMO + 1);
    end
    n_checks++;
    if (sbq.size() == 0) begin
      n_fail++; $display("FAIL timeout_result: scoreboard empty");
    end else begin
      e = sbq.pop_front();
      if ({hi, lo, div0, timeout_err} !== {e.hi, e.lo, e.div0, e.tmo}) begin
        n_fail++;
        $display("FAIL timeout_result: got hi=%h lo=%h div0=%b tmo=%b want %h %h %b %b",
                 hi, lo, div0, timeout_err, e.hi, e.lo, e.div0, e.tmo);
      end
    end
    cyc(1);
    // Done on the very last WAIT cycle beats the abort.
    sbq.push_back('{hi: 32'haa, lo: 32'hbb, div0: 1'b0, tmo: 1'b0});
    issue(1'b0, 32'd1, 32'd1);
    cyc(TMO);
    unit_pulse(1'b0, 32'haa, 32'hbb);
`else
    sbq.push_back('{hi: 32'h5, lo: 32'h6, div0: 1'b0, tmo: 1'b0});
    issue(1'b0, 32'd3, 32'd3);
    cyc(TMO + 20);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0 || timeout_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_holds: got busy=%b done=%b tmo=%b want 1 0 0", busy, done, timeout_err);
    end
    unit_pulse(1'b0, 32'h5, 32'h6);
`endif
    wait_done(5, w);
    n_checks++;
    if (sbq.size() == 0) begin
      n_fail++; $display("FAIL late_result: scoreboard empty");
    end else begin
      e = sbq.pop_front();
      if (done !== 1'b1 || {hi, lo, div0, timeout_err} !== {e.hi, e.lo, e.div0, e.tmo}) begin
        n_fail++;
        $display("FAIL late_result: got done=%b hi=%h lo=%h div0=%b tmo=%b want 1 %h %h %b %b",
                 done, hi, lo, div0, timeout_err, e.hi, e.lo, e.div0, e.tmo);
      end
    end
    cyc(2);
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div0;
    test_ignored_inputs;
    test_reset_mid;
    test_timeout;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
